// File: rtl/conv_row_loader_pkg.sv
// ============================================================================
// conv_pkg: shared constants, loader state encoding and index-width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int DEFAULT_ROW_W    = 6;
  localparam int DEFAULT_NUM_ROWS = 6;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_FULL    = 2'd1,
    ST_PRESENT = 2'd2
  } loader_state_e;

  // Width able to hold every count from 0 up to and including n.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_row_loader_if.sv
// ============================================================================
// conv_row_loader_if: row input, frame handshake and status bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface conv_row_loader_if #(
  parameter int ROW_W    = conv_pkg::DEFAULT_ROW_W,
  parameter int NUM_ROWS = conv_pkg::DEFAULT_NUM_ROWS
) ();
  import conv_pkg::*;

  localparam int IDX_W = idx_width(NUM_ROWS);

  logic [ROW_W-1:0]          row_data;
  logic                      row_strobe;
  logic                      load_req;
  logic                      clear;
  logic                      frame_ack;
  logic [NUM_ROWS*ROW_W-1:0] frame_out;
  logic                      frame_valid;
  logic [IDX_W-1:0]          row_count;
  logic                      full;
  logic                      overflow;

  modport slave (
    input  row_data, row_strobe, load_req, clear, frame_ack,
    output frame_out, frame_valid, row_count, full, overflow
  );

  modport master (
    output row_data, row_strobe, load_req, clear, frame_ack,
    input  frame_out, frame_valid, row_count, full, overflow
  );

endinterface

`default_nettype wire

// File: rtl/conv_row_loader_sync_edge_detect.sv
// ============================================================================
// sync_edge_detect: 2-flop synchroniser followed by a rising-edge pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic async_in,
  output logic      pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/conv_row_loader.sv
// ============================================================================
// conv_row_loader: edge-triggered row buffer presenting whole frames with a
// valid/ack handshake. Option macro: ROW_LOADER_PINGPONG_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module conv_row_loader
  import conv_pkg::*;
#(
  parameter int ROW_W    = DEFAULT_ROW_W,
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS
) (
  input wire logic          clk,
  input wire logic          rst_n,
  conv_row_loader_if.slave  bus
);

  localparam int               IDX_W    = idx_width(NUM_ROWS);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(NUM_ROWS);

  loader_state_e                      state_q, state_d;
  logic [IDX_W-1:0]                   row_count_q, row_count_d;
  logic [NUM_ROWS-1:0][ROW_W-1:0]     row_buf_q, row_buf_d;
  logic [NUM_ROWS*ROW_W-1:0]          frame_out_q, frame_out_d;
  logic                               frame_valid_q, frame_valid_d;
  logic                               overflow_q, overflow_d;
  logic                               strobe_pulse;
  logic                               load_pulse;
`ifdef ROW_LOADER_PINGPONG_EN
  logic                               load_pending_q, load_pending_d;
`endif

  sync_edge_detect u_strobe_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.row_strobe),
    .pulse    (strobe_pulse)
  );

  sync_edge_detect u_load_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.load_req),
    .pulse    (load_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      row_count_q    <= '0;
      row_buf_q      <= '0;
      frame_out_q    <= '0;
      frame_valid_q  <= 1'b0;
      overflow_q     <= 1'b0;
`ifdef ROW_LOADER_PINGPONG_EN
      load_pending_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      row_count_q    <= row_count_d;
      row_buf_q      <= row_buf_d;
      frame_out_q    <= frame_out_d;
      frame_valid_q  <= frame_valid_d;
      overflow_q     <= overflow_d;
`ifdef ROW_LOADER_PINGPONG_EN
      load_pending_q <= load_pending_d;
`endif
    end
  end

  // Next state reads the datapath's next count/pending so both stay in step.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL:    if (row_count_d == FULL_CNT) state_d = ST_FULL;
        ST_FULL:    if (load_pulse) state_d = ST_PRESENT;
        ST_PRESENT: begin
`ifdef ROW_LOADER_PINGPONG_EN
          if (frame_valid_q && bus.frame_ack && !load_pending_d)
            state_d = (row_count_d == FULL_CNT) ? ST_FULL : ST_FILL;
`else
          if (bus.frame_ack) state_d = ST_FILL;
`endif
        end
        default:    state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    row_count_d    = row_count_q;
    row_buf_d      = row_buf_q;
    frame_out_d    = frame_out_q;
    frame_valid_d  = frame_valid_q;
    overflow_d     = overflow_q;
`ifdef ROW_LOADER_PINGPONG_EN
    load_pending_d = load_pending_q;
`endif
    if (bus.clear) begin
      row_count_d    = '0;
      frame_valid_d  = 1'b0;
      overflow_d     = 1'b0;
`ifdef ROW_LOADER_PINGPONG_EN
      load_pending_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FILL: begin
          if (strobe_pulse) begin
            for (int r = 0; r < NUM_ROWS; r++)
              if (row_count_q == IDX_W'(r)) row_buf_d[r] = bus.row_data;
            row_count_d = row_count_q + 1'b1;
          end
        end
        ST_FULL: begin
          if (strobe_pulse) overflow_d = 1'b1;
          if (load_pulse) begin
            frame_out_d   = row_buf_q;
            frame_valid_d = 1'b1;
`ifdef ROW_LOADER_PINGPONG_EN
            row_count_d   = '0;
`endif
          end
        end
        ST_PRESENT: begin
`ifdef ROW_LOADER_PINGPONG_EN
          if (strobe_pulse) begin
            if (row_count_q != FULL_CNT) begin
              for (int r = 0; r < NUM_ROWS; r++)
                if (row_count_q == IDX_W'(r)) row_buf_d[r] = bus.row_data;
              row_count_d = row_count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (load_pulse && frame_valid_q && row_count_q == FULL_CNT)
            load_pending_d = 1'b1;
          if (frame_valid_q && bus.frame_ack)
            frame_valid_d = 1'b0;
          // Deferred transfer lands one edge after the ack edge.
          if (!frame_valid_q && load_pending_q) begin
            frame_out_d    = row_buf_q;
            frame_valid_d  = 1'b1;
            load_pending_d = 1'b0;
            row_count_d    = '0;
          end
`else
          if (strobe_pulse) overflow_d = 1'b1;
          if (bus.frame_ack) begin
            frame_valid_d = 1'b0;
            row_count_d   = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.frame_out   = frame_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.row_count   = row_count_q;
  assign bus.full        = (row_count_q == FULL_CNT);
  assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_row_loader.sv
// ============================================================================
// tb_conv_row_loader: directed self-checking bench for conv_row_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_row_loader;

  localparam int ROW_W    = 6;
  localparam int NUM_ROWS = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [NUM_ROWS*ROW_W-1:0] frame_a, frame_c, frame_d;

  conv_row_loader_if #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS)) bus ();

  conv_row_loader #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_row(input logic [ROW_W-1:0] data);
    bus.row_data   = data;
    bus.row_strobe = 1'b1;
    tick(3);
    bus.row_strobe = 1'b0;
    tick(3);
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    tick(3);
    bus.load_req = 1'b0;
    tick(3);
  endtask

  initial begin
    frame_a = {6'h06, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01};
    frame_c = {6'h16, 6'h15, 6'h14, 6'h13, 6'h12, 6'h11};
    frame_d = {6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21};
    bus.row_data   = '0;
    bus.row_strobe = 1'b0;
    bus.load_req   = 1'b0;
    bus.clear      = 1'b0;
    bus.frame_ack  = 1'b0;

    #2;
    check("rst_valid",    bus.frame_valid, 0);
    check("rst_count",    bus.row_count,   0);
    check("rst_full",     bus.full,        0);
    check("rst_overflow", bus.overflow,    0);
    check("rst_frame",    bus.frame_out,   0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Partial frame, then asynchronous reset mid-operation
    strobe_row(6'h2A);
    strobe_row(6'h2B);
    strobe_row(6'h2C);
    check("pre_rst_count", bus.row_count, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_count", bus.row_count,   0);
    check("midrst_valid", bus.frame_valid, 0);
    check("midrst_full",  bus.full,        0);
    check("midrst_frame", bus.frame_out,   0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Strobe-to-count latency, then a held level writes only one row
    bus.row_data   = 6'h01;
    bus.row_strobe = 1'b1;
    tick(1);
    check("lat_k1", bus.row_count, 0);
    tick(1);
    check("lat_k2", bus.row_count, 0);
    tick(1);
    check("lat_k3", bus.row_count, 1);
    tick(10);
    check("held_strobe", bus.row_count, 1);
    bus.row_strobe = 1'b0;
    tick(3);

    strobe_row(6'h02);
    strobe_row(6'h03);
    strobe_row(6'h04);
    check("count4", bus.row_count, 4);
    check("full4",  bus.full,      0);

    pulse_load();
    check("partial_load_valid", bus.frame_valid, 0);
    check("partial_load_ovf",   bus.overflow,    0);
    check("partial_load_count", bus.row_count,   4);

    strobe_row(6'h05);
    check("full5", bus.full, 0);
    strobe_row(6'h06);
    check("count6", bus.row_count, 6);
    check("full6",  bus.full,      1);

    strobe_row(6'h3F);
    check("ovf_set",   bus.overflow,  1);
    check("ovf_count", bus.row_count, 6);

    bus.load_req = 1'b1;
    tick(2);
    check("load_lat2", bus.frame_valid, 0);
    tick(1);
    check("load_lat3_valid", bus.frame_valid, 1);
    check("frame_a",         bus.frame_out,   frame_a);
    bus.load_req = 1'b0;
    tick(3);
    check("ovf_sticky", bus.overflow, 1);

    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("ack_hold", {bus.frame_valid, bus.frame_out}, {1'b1, frame_a});
    end

    bus.frame_ack = 1'b1;
    tick(1);
    bus.frame_ack = 1'b0;
    check("ack_valid", bus.frame_valid, 0);
    check("ack_count", bus.row_count,   0);
    check("ack_frame", bus.frame_out,   frame_a);

    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check("clear_ovf",   bus.overflow,  0);
    check("clear_count", bus.row_count, 0);
    check("clear_frame", bus.frame_out, frame_a);

    bus.frame_ack = 1'b1;
    tick(2);
    bus.frame_ack = 1'b0;
    check("stray_ack_valid", bus.frame_valid, 0);
    check("stray_ack_count", bus.row_count,   0);

    // Last row and load on the same edge: row written, load ignored
    strobe_row(6'h11);
    strobe_row(6'h12);
    strobe_row(6'h13);
    strobe_row(6'h14);
    strobe_row(6'h15);
    bus.row_data   = 6'h16;
    bus.row_strobe = 1'b1;
    bus.load_req   = 1'b1;
    tick(3);
    check("simul_count", bus.row_count,   6);
    check("simul_full",  bus.full,        1);
    check("simul_valid", bus.frame_valid, 0);
    bus.row_strobe = 1'b0;
    bus.load_req   = 1'b0;
    tick(3);
    check("simul_valid_later", bus.frame_valid, 0);

    pulse_load();
    check("frame_c_valid", bus.frame_valid, 1);
    check("frame_c",       bus.frame_out,   frame_c);

`ifdef ROW_LOADER_PINGPONG_EN
    check("pp_count_after_xfer", bus.row_count, 0);
    strobe_row(6'h21);
    strobe_row(6'h22);
    strobe_row(6'h23);
    strobe_row(6'h24);
    strobe_row(6'h25);
    strobe_row(6'h26);
    check("pp_fill_count", bus.row_count,   6);
    check("pp_fill_ovf",   bus.overflow,    0);
    check("pp_fill_frame", bus.frame_out,   frame_c);
    pulse_load();
    check("pp_pend_valid", bus.frame_valid, 1);
    check("pp_pend_frame", bus.frame_out,   frame_c);
    bus.frame_ack = 1'b1;
    tick(1);
    bus.frame_ack = 1'b0;
    check("pp_gap_valid", bus.frame_valid, 0);
    tick(1);
    check("pp_xfer_valid", bus.frame_valid, 1);
    check("pp_xfer_frame", bus.frame_out,   frame_d);
    check("pp_xfer_count", bus.row_count,   0);
`else
    strobe_row(6'h21);
    check("present_strobe_ovf",   bus.overflow,    1);
    check("present_strobe_count", bus.row_count,   6);
    check("present_strobe_frame", bus.frame_out,   frame_c);
    check("present_strobe_valid", bus.frame_valid, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
